// File: rtl/subtractor_serial.sv
// Bit-serial subtractor: d = a - b - bin over WIDTH bits, one bit per clock, LSB first.
// Define SUBTRACTOR_SERIAL_FLAGS_EN to add the registered eq/ovf result flags.
module subtractor_serial #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SUBTRACTOR_SERIAL_FLAGS_EN
    ,
    output logic             eq,
    output logic             ovf
`endif
);

    // Wide enough to hold WIDTH itself, so the count can never wrap early.
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic {StIdle, StRun} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic             br_q;
    logic [CntW-1:0]  cnt_q;

    logic             a_i;
    logic             b_i;
    logic             diff_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

`ifdef SUBTRACTOR_SERIAL_FLAGS_EN
    logic a_msb_q;
    logic b_msb_q;
`endif

    always_comb begin
        a_i      = a_sh_q[0];
        b_i      = b_sh_q[0];
        diff_bit = a_i ^ b_i ^ br_q;
        br_next  = (~a_i & b_i) | (~(a_i ^ b_i) & br_q);
        // Difference bits enter from the MSB side; after WIDTH shifts bit 0 lands at d[0].
        res_next            = res_q >> 1;
        res_next[WIDTH-1]   = diff_bit;
        last_bit = (cnt_q == CntW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            d       <= '0;
            bout    <= 1'b0;
`ifdef SUBTRACTOR_SERIAL_FLAGS_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            eq      <= 1'b0;
            ovf     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        br_q    <= bin;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
`ifdef SUBTRACTOR_SERIAL_FLAGS_EN
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1];
`endif
                    end
                end
                StRun: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    br_q   <= br_next;
                    res_q  <= res_next;
                    cnt_q  <= cnt_q + CntW'(1);
                    if (last_bit) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        d       <= res_next;
                        bout    <= br_next;
`ifdef SUBTRACTOR_SERIAL_FLAGS_EN
                        eq      <= (res_next == '0);
                        ovf     <= (a_msb_q != b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_subtractor_serial.sv
// Self-checking bench for subtractor_serial at WIDTH 4, 1 and 32.
// Flag checks are compiled in when SUBTRACTOR_SERIAL_FLAGS_EN is defined.
module tb_subtractor_serial;

    logic clk;
    logic rst_n;

    logic       start4, bin4, busy4, done4, bout4;
    logic [3:0] a4, b4, d4;
    logic       start1, bin1, busy1, done1, bout1;
    logic [0:0] a1, b1, d1;
    logic        start32, bin32, busy32, done32, bout32;
    logic [31:0] a32, b32, d32;
`ifdef SUBTRACTOR_SERIAL_FLAGS_EN
    logic eq4, ovf4, eq1, ovf1, eq32, ovf32;
`endif

    int tests;
    int fails;

    subtractor_serial #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .d(d4), .bout(bout4)
`ifdef SUBTRACTOR_SERIAL_FLAGS_EN
        , .eq(eq4), .ovf(ovf4)
`endif
    );

    subtractor_serial #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .d(d1), .bout(bout1)
`ifdef SUBTRACTOR_SERIAL_FLAGS_EN
        , .eq(eq1), .ovf(ovf1)
`endif
    );

    subtractor_serial #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32), .bin(bin32),
        .busy(busy32), .done(done32), .d(d32), .bout(bout32)
`ifdef SUBTRACTOR_SERIAL_FLAGS_EN
        , .eq(eq32), .ovf(ovf32)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] d;
        logic       bout;
        logic       eq;
        logic       ovf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One WIDTH=4 operation with latency checks; operands are scrambled right after accept
    // and a stray start pulse is issued mid-run.
    task automatic run4(input logic [3:0] ta, input logic [3:0] tb, input logic tbin,
                        input logic [3:0] ed, input logic eb, input logic eeq, input logic eovf,
                        input string tag);
        @(negedge clk);
        a4 = ta; b4 = tb; bin4 = tbin; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0; a4 = ~ta; b4 = ~tb; bin4 = ~tbin;
        check({tag, " busy after accept"}, busy4, 1);
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            start4 = (k == 1);
            check({tag, " no early done"}, done4, 0);
        end
        start4 = 1'b0;
        @(posedge clk); #1;
        check({tag, " done"}, done4, 1);
        check({tag, " busy low"}, busy4, 0);
        check({tag, " d"}, d4, ed);
        check({tag, " bout"}, bout4, eb);
`ifdef SUBTRACTOR_SERIAL_FLAGS_EN
        check({tag, " eq"}, eq4, eeq);
        check({tag, " ovf"}, ovf4, eovf);
`else
        if (eeq === 1'bx || eovf === 1'bx) check({tag, " flag vector"}, 0, 1);
`endif
    endtask

    task automatic run1(input logic ta, input logic tb, input logic tbin);
        logic [1:0] r;
        r = {1'b0, ta} - {1'b0, tb} - {1'b0, tbin};
        @(negedge clk);
        a1 = ta; b1 = tb; bin1 = tbin; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; a1 = ~ta; b1 = ~tb;
        @(posedge clk); #1;
        check("w1 done", done1, 1);
        check("w1 d", d1, r[0]);
        check("w1 bout", bout1, r[1]);
`ifdef SUBTRACTOR_SERIAL_FLAGS_EN
        check("w1 eq", eq1, r[0] == 1'b0);
        check("w1 ovf", ovf1, (ta != tb) && (r[0] != ta));
`endif
    endtask

    task automatic run32(input logic [31:0] ta, input logic [31:0] tb, input logic tbin);
        logic [32:0] r;
        r = {1'b0, ta} - {1'b0, tb} - {32'd0, tbin};
        @(negedge clk);
        a32 = ta; b32 = tb; bin32 = tbin; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0; a32 = ~ta; b32 = ~tb;
        repeat (31) @(posedge clk);
        #1;
        check("w32 no early done", done32, 0);
        @(posedge clk); #1;
        check("w32 done", done32, 1);
        check("w32 d", d32, r[31:0]);
        check("w32 bout", bout32, r[32]);
`ifdef SUBTRACTOR_SERIAL_FLAGS_EN
        check("w32 eq", eq32, r[31:0] == 32'd0);
        check("w32 ovf", ovf32, (ta[31] != tb[31]) && (r[31] != ta[31]));
`endif
    endtask

    vec_t vecs[8];

    initial begin
        logic [4:0] r5;
        logic [3:0] bb_a[3];
        logic [3:0] bb_b[3];
        logic       bb_bin[3];
        logic [3:0] bb_d[3];
        logic       bb_bo[3];
        int         seen_done;

        tests = 0;
        fails = 0;
        //           a        b        bin   d        bout  eq    ovf
        vecs[0] = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{4'b0101, 4'b0011, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{4'b1010, 4'b0101, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{4'b0011, 4'b0011, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0};

        bb_a   = '{4'b0110, 4'b0010, 4'b1001};
        bb_b   = '{4'b0010, 4'b0110, 4'b1001};
        bb_bin = '{1'b0, 1'b0, 1'b1};
        bb_d   = '{4'b0100, 4'b1100, 4'b1111};
        bb_bo  = '{1'b0, 1'b1, 1'b1};

        start4 = 0; a4 = 0; b4 = 0; bin4 = 0;
        start1 = 0; a1 = 0; b1 = 0; bin1 = 0;
        start32 = 0; a32 = 0; b32 = 0; bin32 = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy4, 0);
        check("reset done", done4, 0);
        check("reset d", d4, 0);
        check("reset bout", bout4, 0);
`ifdef SUBTRACTOR_SERIAL_FLAGS_EN
        check("reset eq", eq4, 0);
        check("reset ovf", ovf4, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run4(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bout,
                 vecs[i].eq, vecs[i].ovf, $sformatf("vec%0d", i));
        end

        // Back-to-back with start held high: one result every 5 cycles.
        @(negedge clk);
        a4 = bb_a[0]; b4 = bb_b[0]; bin4 = bb_bin[0]; start4 = 1'b1;
        @(posedge clk); #1;
        check("b2b accept0", busy4, 1);
        for (int i = 0; i < 3; i++) begin
            for (int k = 1; k < 4; k++) begin
                @(posedge clk); #1;
                check($sformatf("b2b%0d busy mid", i), busy4, 1);
                check($sformatf("b2b%0d no done", i), done4, 0);
            end
            @(posedge clk); #1;
            check($sformatf("b2b%0d done", i), done4, 1);
            check($sformatf("b2b%0d d", i), d4, bb_d[i]);
            check($sformatf("b2b%0d bout", i), bout4, bb_bo[i]);
            if (i < 2) begin
                a4 = bb_a[i+1]; b4 = bb_b[i+1]; bin4 = bb_bin[i+1];
                @(posedge clk); #1;
                check($sformatf("b2b%0d reaccept", i), busy4, 1);
                check($sformatf("b2b%0d done single", i), done4, 0);
            end
        end
        start4 = 1'b0;

        // Reset two cycles into a run aborts it with no later done.
        @(negedge clk);
        a4 = 4'b0011; b4 = 4'b0001; bin4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort busy", busy4, 0);
        check("abort done", done4, 0);
        check("abort d", d4, 0);
        check("abort bout", bout4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done4) seen_done++;
        end
        check("abort no done", seen_done, 0);
        check("abort idle", busy4, 0);

        // Exhaustive WIDTH=4 sweep against reference arithmetic.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    r5 = 5'(ia) - 5'(ib) - 5'(ic);
                    run4(4'(ia), 4'(ib), 1'(ic), r5[3:0], r5[4], r5[3:0] == 4'd0,
                         (4'(ia) >> 3) != (4'(ib) >> 3) && r5[3] != 1'((ia >> 3) & 1),
                         "sweep");
                end
            end
        end

        for (int i = 0; i < 16; i++) begin
            run1(1'($urandom), 1'($urandom), 1'($urandom));
        end
        run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run32(32'h0000_0000, 32'h0000_0001, 1'b0);
        run32(32'h8000_0000, 32'h0000_0001, 1'b0);
        for (int i = 0; i < 20; i++) begin
            run32($urandom, $urandom, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
